hist_mem_sched: RTL and testbench
=================================

Name: hist_mem_sched

Overview:
- Scheduler for the shared 16K x 8 histogram-predict memory port.
- Sequences one frame: clears the memory, grants it to the HCU for accumulation, then grants it to the DCU for readout.
- Drives the memory mux select, and injects the clear writes onto the HCU-side mux inputs.
- Sits between the HCU/DCU and the predict-memory mux. The mux is unchanged and receives sel plus the gated HCU-side signals from this block.

Parameters:
- ADDR_W, 14, memory address width.
- DATA_W, 8, histogram bin width.
- DEPTH, 16384, number of entries to clear. Must be ≤ 2**ADDR_W; reduced in simulation.
- CLR_EN, 1, 1 = run the CLEAR phase on start; 0 = skip it.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- hcu_wen  in  1  HCU write enable.
- hcu_wdata  in  DATA_W  HCU write data.
- hcu_addr  in  ADDR_W  HCU address.
- hcu_ren  in  1  HCU read enable.
- hcu_done  in  1  HCU accumulation finished, 1-cycle pulse.
- dcu_done  in  1  DCU readout finished, 1-cycle pulse.
- mux_hcu_wen  out  1  to mux HCU-side write enable.
- mux_hcu_wdata  out  DATA_W  to mux HCU-side write data.
- mux_hcu_addr  out  ADDR_W  to mux HCU-side address.
- mux_hcu_ren  out  1  to mux HCU-side read enable.
- sel  out  1  mux select: 0 = HCU side, 1 = DCU side.
- hcu_grant  out  1  HCU may access memory.
- dcu_grant  out  1  DCU may access memory.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse at frame end.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, clear counter 0. All outputs 0, including sel.
- FSM states, registered: IDLE, CLEAR, HCU, SWITCH, DCU, DONE.
- All outputs are combinational decodes of the registered state and counter. No input-to-output path exists except the HCU pass-through in state HCU.
- IDLE:
  - On start: next state CLEAR if CLR_EN=1, else HCU. The counter is loaded with 0.
  - start is ignored in every other state.
- CLEAR:
  - Outputs: mux_hcu_wen=1, mux_hcu_addr=counter, mux_hcu_wdata=0, mux_hcu_ren=0, sel=0. Both grants are 0.
  - The counter increments each cycle. At counter==DEPTH-1 the last write is issued, and the next state is HCU.
  - Exactly DEPTH write cycles; the address width never wraps.
- HCU:
  - hcu_grant=1, sel=0. mux_hcu_* equal the hcu_* inputs.
  - hcu_done → SWITCH.
- In every state except HCU and CLEAR, mux_hcu_* are forced to 0. HCU requests outside its grant are dropped, not queued.
- SWITCH:
  - One bubble cycle: both grants 0, mux_hcu_* 0, sel=0.
  - Guarantees the last HCU write completes before the DCU reads. Always → DCU.
- DCU: sel=1, dcu_grant=1, mux_hcu_* 0. dcu_done → DONE.
- DONE: done=1 for one cycle, sel=0, then → IDLE.
- hcu_done or dcu_done arriving outside its own state is ignored.
- Simultaneous hcu_done with abort: abort wins.
- abort, synchronous, highest priority: next state IDLE and counter cleared. done is not asserted.
  - An abort during CLEAR leaves the memory partially cleared; no recovery is attempted.
- busy=1 in all states except IDLE.
- Frame latency with CLR_EN=1:
  - start at cycle t → first clear write at t+1.
  - HCU grant at t+1+DEPTH.
  - DCU grant 2 cycles after the hcu_done cycle.
  - done 1 cycle after the dcu_done cycle.

Decomposition:
- Shared package hist_pkg:
  - state enum (IDLE..DONE, 3-bit encoding)
  - HIST_ADDR_W=14, HIST_DATA_W=8, HIST_DEPTH=16384
- hist_mem_sched and the testbench import these.
- One natural sub-module, hist_clr_cnt: an ADDR_W+1-bit counter with load, enable and a terminal flag at DEPTH-1.
- The FSM and output decode stay in the top module.

Test Plan:
- Use DEPTH=16, CLR_EN=1 unless stated.
- Reset then idle: rst_n low mid-run → all outputs 0 asynchronously, state IDLE. Release, hold start=0 for 10 cycles → busy=0, sel=0.
- Full frame: start pulse → 16 clear writes, addr 0..15, wdata 0x00.
  - hcu_grant rises on cycle 17.
  - HCU writes addr 0x0005 data 0xA3 → mux_hcu_* match.
  - hcu_done → one SWITCH cycle, then sel=1, dcu_grant=1.
  - dcu_done → done pulse, busy drops next cycle.
- Gating: drive hcu_wen=1, addr 0x3FFF, data 0xFF during CLEAR, SWITCH and DCU → mux_hcu_wen shows only clear writes, never 0xFF data.
- CLR_EN=0: start → hcu_grant on the next cycle with no clear writes. Stray dcu_done during HCU is ignored.
- Abort: assert abort at clear counter 7 → next cycle IDLE, counter 0, no done pulse. A following start restarts the clear at addr 0.
- Corners: start held high through the whole frame → exactly one frame, then a new frame starts from IDLE. hcu_done together with abort → IDLE, dcu_grant never asserted.

Source files
------------

// File: rtl/hist_pkg.sv
// ---------------------------------------------------------------------------
// hist_pkg
// Shared definitions for the histogram-predict memory scheduler:
//   - default memory geometry (address width, bin width, depth)
//   - scheduler state encoding
// ---------------------------------------------------------------------------
package hist_pkg;

    localparam int HIST_ADDR_W = 14;
    localparam int HIST_DATA_W = 8;
    localparam int HIST_DEPTH  = 16384;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_HCU    = 3'd2,
        ST_SWITCH = 3'd3,
        ST_DCU    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/hist_mem_sched_if.sv
// ---------------------------------------------------------------------------
// hist_mem_sched_if
// HCU memory-access bus as seen by the scheduler.
//   hcu_wen/hcu_wdata/hcu_addr/hcu_ren         : raw HCU requests
//   mux_hcu_wen/mux_hcu_wdata/mux_hcu_addr/... : gated requests toward the mux
// Modports:
//   master : HCU/mux environment (drives hcu_*, observes mux_hcu_*)
//   slave  : scheduler (observes hcu_*, drives mux_hcu_*)
// ---------------------------------------------------------------------------
interface hist_mem_sched_if import hist_pkg::*; #(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W
) ();

    logic              hcu_wen;
    logic [DATA_W-1:0] hcu_wdata;
    logic [ADDR_W-1:0] hcu_addr;
    logic              hcu_ren;

    logic              mux_hcu_wen;
    logic [DATA_W-1:0] mux_hcu_wdata;
    logic [ADDR_W-1:0] mux_hcu_addr;
    logic              mux_hcu_ren;

    modport master (
        output hcu_wen, hcu_wdata, hcu_addr, hcu_ren,
        input  mux_hcu_wen, mux_hcu_wdata, mux_hcu_addr, mux_hcu_ren
    );

    modport slave (
        input  hcu_wen, hcu_wdata, hcu_addr, hcu_ren,
        output mux_hcu_wen, mux_hcu_wdata, mux_hcu_addr, mux_hcu_ren
    );

endinterface

// File: rtl/hist_clr_cnt.sv
// ---------------------------------------------------------------------------
// hist_clr_cnt
// Clear-address counter, one bit wider than the address so the full depth
// is representable without wrapping.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : synchronous load to zero (wins over en)
//   en         : increment by one
//   cnt        : current count (ADDR_W+1 bits)
//   last       : count equals DEPTH-1
// ---------------------------------------------------------------------------
module hist_clr_cnt import hist_pkg::*; #(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DEPTH  = HIST_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    output logic [ADDR_W:0] cnt,
    output logic            last
);

    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [ADDR_W:0] cnt_r;

    // Counter register: load has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == CNT_LAST);

endmodule

// File: rtl/hist_mem_sched.sv
// ---------------------------------------------------------------------------
// hist_mem_sched
// Frame scheduler for the shared histogram-predict memory port.
// Sequence per frame: CLEAR (optional) -> HCU -> SWITCH -> DCU -> DONE.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : frame start pulse, honoured only in IDLE
//   abort               : synchronous abort, highest priority, back to IDLE
//   hcu_done, dcu_done  : phase-finished pulses from HCU / DCU
//   bus (slave)         : HCU requests in, gated/clear requests to the mux
//   sel                 : mux select, 0 = HCU side, 1 = DCU side
//   hcu_grant/dcu_grant : access grants
//   busy                : not IDLE
//   done                : one-cycle frame-end pulse
// All outputs decode the registered state and clear counter; the only
// input-to-output path is the HCU pass-through while in HCU.
// ---------------------------------------------------------------------------
module hist_mem_sched import hist_pkg::*; #(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int DATA_W = HIST_DATA_W,
    parameter int DEPTH  = HIST_DEPTH,
    parameter bit CLR_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hcu_done,
    input  logic                 dcu_done,
    hist_mem_sched_if.slave      bus,
    output logic                 sel,
    output logic                 hcu_grant,
    output logic                 dcu_grant,
    output logic                 busy,
    output logic                 done
);

    state_t          state_r;
    state_t          state_next_s;
    logic            cnt_load_s;
    logic            cnt_en_s;
    logic [ADDR_W:0] cnt_s;
    logic            cnt_last_s;

    hist_clr_cnt #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load_s),
        .en    (cnt_en_s),
        .cnt   (cnt_s),
        .last  (cnt_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and counter control; abort overrides every transition.
    always_comb begin
        state_next_s = state_r;
        cnt_load_s   = 1'b0;
        cnt_en_s     = 1'b0;
        if (abort) begin
            state_next_s = ST_IDLE;
            cnt_load_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = CLR_EN ? ST_CLEAR : ST_HCU;
                        cnt_load_s   = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    cnt_en_s = 1'b1;
                    if (cnt_last_s) begin
                        state_next_s = ST_HCU;
                    end else begin
                        state_next_s = ST_CLEAR;
                    end
                end
                ST_HCU: begin
                    if (hcu_done) begin
                        state_next_s = ST_SWITCH;
                    end else begin
                        state_next_s = ST_HCU;
                    end
                end
                ST_SWITCH: state_next_s = ST_DCU;
                ST_DCU: begin
                    if (dcu_done) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DCU;
                    end
                end
                ST_DONE:   state_next_s = ST_IDLE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output decode. The counter MSB is always 0 while clearing a legal
    // depth; gating on it keeps a corrupted counter from writing wrapped
    // addresses.
    always_comb begin
        bus.mux_hcu_wen   = 1'b0;
        bus.mux_hcu_wdata = {DATA_W{1'b0}};
        bus.mux_hcu_addr  = {ADDR_W{1'b0}};
        bus.mux_hcu_ren   = 1'b0;
        sel               = 1'b0;
        hcu_grant         = 1'b0;
        dcu_grant         = 1'b0;
        busy              = (state_r != ST_IDLE);
        done              = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                bus.mux_hcu_wen  = ~cnt_s[ADDR_W];
                bus.mux_hcu_addr = cnt_s[ADDR_W-1:0];
            end
            ST_HCU: begin
                hcu_grant         = 1'b1;
                bus.mux_hcu_wen   = bus.hcu_wen;
                bus.mux_hcu_wdata = bus.hcu_wdata;
                bus.mux_hcu_addr  = bus.hcu_addr;
                bus.mux_hcu_ren   = bus.hcu_ren;
            end
            ST_DCU: begin
                sel       = 1'b1;
                dcu_grant = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hist_mem_sched.sv
module tb_hist_mem_sched;
    import hist_pkg::*;

    localparam int AW    = HIST_ADDR_W;
    localparam int DW    = HIST_DATA_W;
    localparam int DEPTH = 16;

    localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_HCU = 2, PH_SWITCH = 3, PH_DCU = 4, PH_DONE = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, hcu_done, dcu_done, hcu_wen, hcu_ren;
    logic [DW-1:0] hcu_wdata;
    logic [AW-1:0] hcu_addr;
    logic sel_a, hg_a, dg_a, busy_a, done_a;
    logic sel_b, hg_b, dg_b, busy_b, done_b;

    hist_mem_sched_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    hist_mem_sched_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

    assign if_a.hcu_wen = hcu_wen;   assign if_b.hcu_wen = hcu_wen;
    assign if_a.hcu_wdata = hcu_wdata; assign if_b.hcu_wdata = hcu_wdata;
    assign if_a.hcu_addr = hcu_addr; assign if_b.hcu_addr = hcu_addr;
    assign if_a.hcu_ren = hcu_ren;   assign if_b.hcu_ren = hcu_ren;

    hist_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLR_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hcu_done(hcu_done), .dcu_done(dcu_done), .bus(if_a.slave),
        .sel(sel_a), .hcu_grant(hg_a), .dcu_grant(dg_a), .busy(busy_a), .done(done_a));

    hist_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLR_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hcu_done(hcu_done), .dcu_done(dcu_done), .bus(if_b.slave),
        .sel(sel_b), .hcu_grant(hg_b), .dcu_grant(dg_b), .busy(busy_b), .done(done_b));

    typedef struct packed {
        logic wen; logic [DW-1:0] wdata; logic [AW-1:0] addr; logic ren;
        logic sel; logic hg; logic dg; logic busy; logic done;
    } out_t;

    typedef struct { int phase; int cnt; } ms_t;

    typedef struct {
        logic st, ab, hw, hr, hd, dd;
        logic [DW-1:0] wd;
        logic [AW-1:0] ad;
        out_t exp;
    } vec_t;

    ms_t  ma, mb;
    int   tests = 0;
    int   fails = 0;
    vec_t vt[9];

    function automatic out_t mko(logic wen, logic [DW-1:0] wd, logic [AW-1:0] ad, logic ren,
                                 logic s, logic hg, logic dg, logic b, logic d);
        out_t o;
        o.wen = wen; o.wdata = wd; o.addr = ad; o.ren = ren;
        o.sel = s; o.hg = hg; o.dg = dg; o.busy = b; o.done = d;
        return o;
    endfunction

    function automatic vec_t mkv(logic st, logic hw, logic [DW-1:0] wd, logic [AW-1:0] ad,
                                 logic hr, logic hd, logic dd, out_t e);
        vec_t v;
        v.st = st; v.ab = 1'b0; v.hw = hw; v.wd = wd; v.ad = ad; v.hr = hr;
        v.hd = hd; v.dd = dd; v.exp = e;
        return v;
    endfunction

    // Reference model: frame phase plus clear index, advanced by the frame rules.
    function automatic ms_t m_next(ms_t s, bit clr_en);
        ms_t n = s;
        if (abort) begin
            n.phase = PH_IDLE; n.cnt = 0;
        end else begin
            case (s.phase)
                PH_IDLE:   if (start) begin n.phase = clr_en ? PH_CLEAR : PH_HCU; n.cnt = 0; end
                PH_CLEAR:  begin
                    if (s.cnt == DEPTH - 1) n.phase = PH_HCU;
                    n.cnt = s.cnt + 1;
                end
                PH_HCU:    if (hcu_done) n.phase = PH_SWITCH;
                PH_SWITCH: n.phase = PH_DCU;
                PH_DCU:    if (dcu_done) n.phase = PH_DONE;
                default:   n.phase = PH_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic out_t m_out(ms_t s);
        out_t o = '0;
        o.busy = (s.phase != PH_IDLE);
        if (s.phase == PH_CLEAR) begin
            o.wen = 1'b1; o.addr = AW'(s.cnt);
        end
        if (s.phase == PH_HCU) begin
            o.hg = 1'b1; o.wen = hcu_wen; o.wdata = hcu_wdata; o.addr = hcu_addr; o.ren = hcu_ren;
        end
        if (s.phase == PH_DCU) begin
            o.sel = 1'b1; o.dg = 1'b1;
        end
        if (s.phase == PH_DONE) o.done = 1'b1;
        return o;
    endfunction

    function automatic out_t act_a();
        return mko(if_a.mux_hcu_wen, if_a.mux_hcu_wdata, if_a.mux_hcu_addr, if_a.mux_hcu_ren,
                   sel_a, hg_a, dg_a, busy_a, done_a);
    endfunction

    function automatic out_t act_b();
        return mko(if_b.mux_hcu_wen, if_b.mux_hcu_wdata, if_b.mux_hcu_addr, if_b.mux_hcu_ren,
                   sel_b, hg_b, dg_b, busy_b, done_b);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        start = 1'b0; abort = 1'b0; hcu_done = 1'b0; dcu_done = 1'b0;
        hcu_wen = 1'b0; hcu_ren = 1'b0; hcu_wdata = '0; hcu_addr = '0;
    endtask

    // One clock: compare both DUTs with the model, then advance the model.
    task automatic step(string nm);
        #1;
        chk({nm, " dutA"}, 64'(act_a()), 64'(m_out(ma)));
        chk({nm, " dutB"}, 64'(act_b()), 64'(m_out(mb)));
        @(posedge clk);
        if (rst_n) begin
            ma = m_next(ma, 1'b1);
            mb = m_next(mb, 1'b0);
        end else begin
            ma.phase = PH_IDLE; ma.cnt = 0; mb.phase = PH_IDLE; mb.cnt = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int c, nw, asum, ndone, ndg;

        // CLR_EN=0 frame with stray dcu_done pulses, expected outputs of dut B.
        vt[0] = mkv(1'b0, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt[1] = mkv(1'b1, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt[2] = mkv(1'b0, 1'b1, 8'hA3, 14'h0005, 1'b0, 1'b0, 1'b1, mko(1'b1, 8'hA3, 14'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vt[3] = mkv(1'b0, 1'b0, 8'h00, 14'h3FFF, 1'b1, 1'b0, 1'b1, mko(1'b0, 8'h00, 14'h3FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vt[4] = mkv(1'b0, 1'b1, 8'hFF, 14'h3FFF, 1'b0, 1'b1, 1'b0, mko(1'b1, 8'hFF, 14'h3FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vt[5] = mkv(1'b0, 1'b1, 8'hFF, 14'h3FFF, 1'b0, 1'b0, 1'b0, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vt[6] = mkv(1'b0, 1'b1, 8'hFF, 14'h3FFF, 1'b0, 1'b0, 1'b1, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        vt[7] = mkv(1'b0, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        vt[8] = mkv(1'b0, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, mko(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        ma.phase = PH_IDLE; ma.cnt = 0; mb.phase = PH_IDLE; mb.cnt = 0;
        rst_n = 1'b0;
        idle_in();
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset outputs A", 64'(act_a()), 64'd0);
        chk("reset outputs B", 64'(act_b()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle");

        // Table-driven frame.
        for (int i = 0; i < 9; i++) begin
            start = vt[i].st; abort = vt[i].ab; hcu_wen = vt[i].hw; hcu_wdata = vt[i].wd;
            hcu_addr = vt[i].ad; hcu_ren = vt[i].hr; hcu_done = vt[i].hd; dcu_done = vt[i].dd;
            #1;
            chk($sformatf("table vec%0d", i), 64'(act_b()), 64'(vt[i].exp));
            step("table");
        end

        // Abort while dut A is at clear index 7, then restart from address 0.
        idle_in();
        abort = 1'b1;
        #1;
        chk("abort clear addr", 64'(if_a.mux_hcu_addr), 64'd7);
        step("abort");
        abort = 1'b0;
        #1;
        chk("abort busy", 64'(busy_a), 64'd0);
        chk("abort no done", 64'(done_a), 64'd0);
        start = 1'b1;
        step("restart");
        start = 1'b0;
        #1;
        chk("restart addr", 64'(if_a.mux_hcu_addr), 64'd0);
        chk("restart wen", 64'(if_a.mux_hcu_wen), 64'd1);
        abort = 1'b1;
        step("abort2");
        abort = 1'b0;

        // Full frame with hostile HCU inputs outside the grant.
        start = 1'b1;
        step("frame start");
        start = 1'b0;
        hcu_wen = 1'b1; hcu_addr = 14'h3FFF; hcu_wdata = 8'hFF; hcu_ren = 1'b1;
        c = 1; nw = 0; asum = 0;
        while (c < 40) begin
            #1;
            if (hg_a) break;
            if (if_a.mux_hcu_wen) begin
                nw++; asum += int'(if_a.mux_hcu_addr);
                if (if_a.mux_hcu_wdata != 8'h00) chk("clear wdata", 64'(if_a.mux_hcu_wdata), 64'd0);
            end
            step("clear");
            c++;
        end
        chk("hcu grant cycle", 64'(c), 64'd17);
        chk("clear write count", 64'(nw), 64'd16);
        chk("clear addr sum", 64'(asum), 64'd120);
        hcu_wen = 1'b1; hcu_addr = 14'h0005; hcu_wdata = 8'hA3; hcu_ren = 1'b0;
        #1;
        chk("hcu pass addr", 64'(if_a.mux_hcu_addr), 64'h5);
        chk("hcu pass data", 64'(if_a.mux_hcu_wdata), 64'hA3);
        step("hcu write");
        hcu_addr = 14'h3FFF; hcu_wdata = 8'hFF; hcu_done = 1'b1;
        step("hcu done");
        hcu_done = 1'b0;
        #1;
        chk("switch bubble", 64'({if_a.mux_hcu_wen, sel_a, hg_a, dg_a}), 64'd0);
        step("switch");
        #1;
        chk("dcu grant", 64'({sel_a, dg_a, if_a.mux_hcu_wen}), 64'b110);
        step("dcu");
        dcu_done = 1'b1;
        step("dcu done");
        dcu_done = 1'b0;
        #1;
        chk("done pulse", 64'(done_a), 64'd1);
        step("done");
        #1;
        chk("busy drops", 64'(busy_a), 64'd0);
        idle_in();
        step("post frame");

        // Asynchronous reset in the middle of a frame.
        start = 1'b1;
        step("rst frame");
        start = 1'b0; hcu_wen = 1'b1; hcu_wdata = 8'h5A; hcu_addr = 14'h0123;
        for (int i = 0; i < 3; i++) step("pre reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset A", 64'(act_a()), 64'd0);
        chk("async reset B", 64'(act_b()), 64'd0);
        ma.phase = PH_IDLE; ma.cnt = 0; mb.phase = PH_IDLE; mb.cnt = 0;
        @(negedge clk);
        step("in reset");
        rst_n = 1'b1;
        idle_in();
        step("after reset");

        // start held high across a whole frame.
        start = 1'b1; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            hcu_done = (i == 25);
            dcu_done = (i == 30);
            #1;
            if (done_a) ndone++;
            step("start held");
        end
        chk("held start done count", 64'(ndone), 64'd1);
        idle_in();
        abort = 1'b1;
        step("held cleanup");
        abort = 1'b0;

        // hcu_done together with abort.
        start = 1'b1;
        step("ha start");
        start = 1'b0;
        c = 0;
        while (c < 40) begin
            #1;
            if (hg_a) break;
            step("ha wait");
            c++;
        end
        chk("ha reached hcu", 64'(hg_a), 64'd1);
        hcu_done = 1'b1; abort = 1'b1;
        step("hcu_done+abort");
        idle_in();
        ndg = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (dg_a) ndg++;
            step("ha after");
        end
        chk("ha dcu grant count", 64'(ndg), 64'd0);
        chk("ha idle", 64'(busy_a), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            hcu_done  = ($urandom_range(0, 7) == 0);
            dcu_done  = ($urandom_range(0, 5) == 0);
            hcu_wen   = $urandom_range(0, 1) == 1;
            hcu_ren   = $urandom_range(0, 1) == 1;
            hcu_wdata = DW'($urandom);
            hcu_addr  = AW'($urandom);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
